// File: rtl/hiscore_pkg.sv
// Shared types for the high-score engine: FSM state encoding and buffer sizing helper.
package hiscore_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK_WAIT,
    ST_CHK_PAUSE,
    ST_CHK_READ,
    ST_RESTORE_PAUSE,
    ST_RESTORE,
    ST_SAVE_PAUSE,
    ST_SAVE,
    ST_DONE
  } hs_state_t;

  function automatic int buf_aw(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/hiscore_buffer.sv
// Score table buffer: port A faces the ioctl host, port B faces the hs_* sequencer.
module hiscore_buffer #(
  parameter int LENGTH = 64,
  parameter int AW     = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_we,
  input  logic          i_a_re,
  input  logic [AW-1:0] i_a_addr,
  input  logic [7:0]    i_a_din,
  output logic [7:0]    o_a_dout,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [7:0]    i_b_din,
  output logic [7:0]    o_b_dout
);

  logic [7:0] r_mem [LENGTH];
  logic [7:0] r_a_dout;
  logic [7:0] r_b_dout;

  always_ff @(posedge i_clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_din;
    if (i_b_we) r_mem[i_b_addr] <= i_b_din;
  end

  // Upload data holds its last value while the host is not reading.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a_dout <= '0;
      r_b_dout <= '0;
    end else begin
      if (i_a_re) r_a_dout <= r_mem[i_a_addr];
      r_b_dout <= r_mem[i_b_addr];
    end
  end

  assign o_a_dout = r_a_dout;
  assign o_b_dout = r_b_dout;

endmodule

// File: rtl/hiscore_engine.sv
// High-score initiator: restores a host-supplied table into work RAM once the game has
// initialised it, and reads the table back on request for upload.
module hiscore_engine import hiscore_pkg::*; #(
  parameter int               HS_AW     = 12,
  parameter logic [HS_AW-1:0] BASE_ADDR = '0,
  parameter int               LENGTH    = 64,
  parameter logic [HS_AW-1:0] CHK_ADDR  = '0,
  parameter logic [7:0]       CHK_VAL   = 8'h00,
  parameter int               RD_LAT    = 2,
  parameter int               SETTLE    = 16
) (
  input  logic             clk_49m,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic             ioctl_upload,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic [7:0]       ioctl_din,
  input  logic             vblank,
  input  logic             save_req,
  output logic [HS_AW-1:0] hs_address,
  output logic [7:0]       hs_wdata,
  input  logic [7:0]       hs_rdata,
  output logic             hs_write_enable,
  output logic             hs_access_read,
  output logic             hs_access_write,
  output logic             pause_cpu,
  output logic             busy,
  output logic             restored
);

  localparam int BUF_AW = buf_aw(LENGTH);

  hs_state_t        r_state;
  logic [15:0]      r_cnt;
  logic [8:0]       r_idx;
  logic [1:0]       r_chk_cnt;
  logic             r_ph, r_loaded, r_wrote, r_dl_d, r_vb_d, r_save_d, r_save_pend;
  logic [HS_AW-1:0] r_addr;
  logic [7:0]       r_wdata;
  logic             r_we, r_rd, r_wr, r_pause, r_restored;

  logic       w_dl_we, w_b_we, w_vb_rise, w_save_rise, w_save_any;
  logic [7:0] w_b_dout;

  assign w_dl_we     = ioctl_download & ioctl_wr & (ioctl_addr < 25'(LENGTH));
  assign w_b_we      = (r_state == ST_SAVE) && (r_cnt == 16'(RD_LAT));
  assign w_vb_rise   = vblank & ~r_vb_d;
  assign w_save_rise = save_req & ~r_save_d;
  assign w_save_any  = r_save_pend | w_save_rise;
  assign busy        = !(r_state == ST_IDLE || r_state == ST_DONE);

  // r_idx sits at 0 outside RESTORE/SAVE, so buffer[0] is already on port B when RESTORE starts.
  hiscore_buffer #(.LENGTH(LENGTH), .AW(BUF_AW)) u_buf (
    .i_clk    (clk_49m),
    .i_reset  (reset),
    .i_a_we   (w_dl_we),
    .i_a_re   (ioctl_upload),
    .i_a_addr (ioctl_addr[BUF_AW-1:0]),
    .i_a_din  (ioctl_dout),
    .o_a_dout (ioctl_din),
    .i_b_we   (w_b_we),
    .i_b_addr (r_idx[BUF_AW-1:0]),
    .i_b_din  (hs_rdata),
    .o_b_dout (w_b_dout)
  );

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_state <= ST_IDLE;  r_cnt <= '0;  r_idx <= '0;  r_chk_cnt <= '0;  r_ph <= 1'b0;
      r_loaded <= 1'b0;  r_wrote <= 1'b0;  r_dl_d <= 1'b0;  r_vb_d <= 1'b0;
      r_save_d <= 1'b0;  r_save_pend <= 1'b0;  r_addr <= '0;  r_wdata <= '0;
      r_we <= 1'b0;  r_rd <= 1'b0;  r_wr <= 1'b0;  r_pause <= 1'b0;  r_restored <= 1'b0;
    end else begin
      r_dl_d   <= ioctl_download;
      r_vb_d   <= vblank;
      r_save_d <= save_req;
      if (ioctl_download && !r_dl_d) r_wrote <= 1'b0;
      if (w_dl_we) r_wrote <= 1'b1;
      if (!ioctl_download && r_dl_d && r_wrote) r_loaded <= 1'b1;
      if (w_save_rise) r_save_pend <= 1'b1;

      if (ioctl_download && busy) begin
        r_state <= ST_IDLE;  r_cnt <= '0;  r_idx <= '0;  r_chk_cnt <= '0;
        r_loaded <= 1'b0;  r_addr <= '0;  r_wdata <= '0;
        r_we <= 1'b0;  r_rd <= 1'b0;  r_wr <= 1'b0;  r_pause <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_save_any) begin
              r_save_pend <= 1'b0;
              r_state     <= ST_SAVE_PAUSE;
              r_pause     <= 1'b1;
              r_cnt       <= '0;
            end else if (r_loaded && !r_restored && !ioctl_download) begin
              r_state   <= ST_CHK_WAIT;
              r_chk_cnt <= '0;
            end
          end
          ST_CHK_WAIT: if (w_vb_rise) begin
            r_state <= ST_CHK_PAUSE;
            r_pause <= 1'b1;
            r_cnt   <= '0;
          end
          ST_CHK_PAUSE: begin
            if (r_cnt == 16'(SETTLE - 1)) begin
              r_state <= ST_CHK_READ;
              r_addr  <= CHK_ADDR;
              r_rd    <= 1'b1;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + 16'd1;
          end
          ST_CHK_READ: begin
            if (r_cnt == 16'(RD_LAT)) begin
              r_rd   <= 1'b0;
              r_addr <= '0;
              r_cnt  <= '0;
              if (hs_rdata == CHK_VAL && r_chk_cnt == 2'd1) begin
                r_chk_cnt <= 2'd2;
                r_state   <= ST_RESTORE_PAUSE;
              end else begin
                r_chk_cnt <= (hs_rdata == CHK_VAL) ? r_chk_cnt + 2'd1 : 2'd0;
                r_state   <= ST_CHK_WAIT;
                r_pause   <= 1'b0;
              end
            end else r_cnt <= r_cnt + 16'd1;
          end
          ST_RESTORE_PAUSE: begin
            if (r_cnt == 16'(SETTLE - 1)) begin
              r_state <= ST_RESTORE;
              r_addr  <= BASE_ADDR;
              r_wdata <= w_b_dout;
              r_wr    <= 1'b1;
              r_idx   <= 9'd1;
              r_ph    <= 1'b0;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + 16'd1;
          end
          // r_ph=0: address/data phase; r_ph=1: strobe phase. r_idx runs one byte ahead.
          ST_RESTORE: begin
            if (!r_ph) begin
              r_we <= 1'b1;
              r_ph <= 1'b1;
            end else if (r_idx == 9'(LENGTH)) begin
              r_we <= 1'b0;  r_wr <= 1'b0;  r_pause <= 1'b0;  r_addr <= '0;  r_wdata <= '0;
              r_idx <= '0;  r_chk_cnt <= '0;  r_restored <= 1'b1;  r_state <= ST_DONE;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= BASE_ADDR + HS_AW'(r_idx);
              r_wdata <= w_b_dout;
              r_idx   <= r_idx + 9'd1;
              r_ph    <= 1'b0;
            end
          end
          ST_SAVE_PAUSE: begin
            if (r_cnt == 16'(SETTLE - 1)) begin
              r_state <= ST_SAVE;
              r_addr  <= BASE_ADDR;
              r_rd    <= 1'b1;
              r_idx   <= '0;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + 16'd1;
          end
          ST_SAVE: begin
            if (r_cnt == 16'(RD_LAT)) begin
              r_cnt <= '0;
              if (r_idx == 9'(LENGTH - 1)) begin
                r_rd <= 1'b0;  r_pause <= 1'b0;  r_addr <= '0;  r_idx <= '0;
                r_state <= ST_DONE;
              end else begin
                r_idx  <= r_idx + 9'd1;
                r_addr <= BASE_ADDR + HS_AW'(r_idx + 9'd1);
              end
            end else r_cnt <= r_cnt + 16'd1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign hs_address      = r_addr;
  assign hs_wdata        = r_wdata;
  assign hs_write_enable = r_we;
  assign hs_access_read  = r_rd;
  assign hs_access_write = r_wr;
  assign pause_cpu       = r_pause;
  assign restored        = r_restored;

endmodule

// File: tb/tb_hiscore_engine.sv
// Randomized bench for hiscore_engine with a work-RAM model and a write/upload scoreboard.
module tb_hiscore_engine;

  localparam int         LEN  = 64;
  localparam logic [11:0] BASE = 12'hFE0;
  localparam logic [11:0] CHKA = 12'h800;
  localparam logic [7:0]  CV   = 8'h5A;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_din;
  logic        vblank = 1'b0, save_req = 1'b0;
  logic [11:0] hs_address;
  logic [7:0]  hs_wdata, hs_rdata;
  logic        hs_write_enable, hs_access_read, hs_access_write, pause_cpu, busy, restored;

  always #5 clk_49m = ~clk_49m;

  hiscore_engine #(.HS_AW(12), .BASE_ADDR(BASE), .LENGTH(LEN), .CHK_ADDR(CHKA),
                   .CHK_VAL(CV), .RD_LAT(2), .SETTLE(16)) dut (
    .clk_49m(clk_49m), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .vblank(vblank), .save_req(save_req),
    .hs_address(hs_address), .hs_wdata(hs_wdata), .hs_rdata(hs_rdata),
    .hs_write_enable(hs_write_enable), .hs_access_read(hs_access_read),
    .hs_access_write(hs_access_write), .pause_cpu(pause_cpu), .busy(busy), .restored(restored)
  );

  typedef struct packed { logic [11:0] addr; logic [7:0] data; } wr_t;

  logic [7:0]  ram [4096];
  logic [11:0] a1 = '0, a2 = '0;
  logic [7:0]  bufm [LEN];
  wr_t         exp_q [$];
  logic [7:0]  upl_q [$];
  logic        upl_pend = 1'b0;
  int          errors = 0, checks = 0;

  // Work RAM: writes land on the strobe, reads return data two clocks after the address.
  always @(posedge clk_49m) begin
    if (hs_write_enable) ram[hs_address] <= hs_wdata;
    a1 <= hs_address;
    a2 <= a1;
    upl_pend <= ioctl_upload;
  end
  assign hs_rdata = ram[a2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk_49m) begin
    if (hs_access_read || hs_access_write || hs_write_enable)
      chk("hs_protocol", 32'({hs_access_read & hs_access_write, hs_write_enable & ~hs_access_write}), 0);
    if (hs_write_enable) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h data %h required no write", hs_address, hs_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("restore_write", 32'({hs_address, hs_wdata}), 32'({e.addr, e.data}));
      end
    end
    if (upl_pend) begin
      if (upl_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_upload: got %h required nothing", ioctl_din);
      end else chk("upload", 32'(ioctl_din), 32'(upl_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk_49m); #1;
  endtask

  task automatic check_quiet(input string nm, input logic [31:0] rest);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_pause"}, 32'(pause_cpu), 0);
    chk({nm, "_hs"}, 32'({hs_address, hs_wdata, hs_write_enable, hs_access_read, hs_access_write}), 0);
    chk({nm, "_restored"}, 32'(restored), rest);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic download(input bit rnd);
    ioctl_download = 1'b1; tick();
    for (int i = 0; i < LEN; i++) begin
      bufm[i] = rnd ? 8'($urandom) : 8'(i);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = bufm[i]; tick();
    end
    // Out-of-range bytes must not alias into the table.
    ioctl_addr = 25'(LEN);  ioctl_dout = 8'hEE; tick();
    ioctl_addr = 25'd200;   tick();
    ioctl_wr = 1'b0; tick();
    ioctl_download = 1'b0; tick();
    for (int i = 0; i < LEN; i++) exp_q.push_back('{addr: BASE + 12'(i), data: bufm[i]});
    repeat (5) tick();
  endtask

  task automatic vbl(input int gap);
    vblank = 1'b1; repeat (4) tick();
    vblank = 1'b0; repeat (gap) tick();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk(nm, 32'(busy), 0);
  endtask

  task automatic wait_restored(input string nm);
    int n = 0;
    while (!restored && n < 2000) begin tick(); n++; end
    chk(nm, 32'(restored), 1);
  endtask

  task automatic upload_check();
    ioctl_upload = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      ioctl_addr = 25'(i); upl_q.push_back(bufm[i]); tick();
    end
    ioctl_upload = 1'b0; tick(); tick();
    chk("upload_drained", 32'(upl_q.size()), 0);
  endtask

  initial begin
    int n, act;
    bit found;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);

    // Reset state
    do_reset();
    check_quiet("reset", 0);
    chk("reset_ioctl_din", 32'(ioctl_din), 0);

    // Straight restore of 0x00..0x3F after two matching frames
    ram[CHKA] = CV;
    download(1'b0);
    vbl(36); vbl(36);
    wait_restored("t1_restored_timeout");
    wait_idle("t1_idle_timeout");
    chk("t1_pause", 32'(pause_cpu), 0);
    chk("t1_writes_left", 32'(exp_q.size()), 0);

    // A mismatching frame restarts the two-frame count
    do_reset();
    ram[CHKA] = CV;
    download(1'b1);
    vbl(36);
    ram[CHKA] = 8'h55; vbl(36);
    ram[CHKA] = CV;    vbl(36);
    chk("t2_waiting_busy", 32'(busy), 1);
    chk("t2_waiting_pause", 32'(pause_cpu), 0);
    chk("t2_not_restored", 32'(restored), 0);
    chk("t2_no_early_writes", 32'(exp_q.size()), LEN);
    vbl(36);
    wait_restored("t2_restored_timeout");
    wait_idle("t2_idle_timeout");
    chk("t2_writes_left", 32'(exp_q.size()), 0);

    // Save from DONE into the buffer, then upload it
    for (int i = 0; i < LEN; i++) begin
      ram[BASE + 12'(i)] = 8'hA0 + 8'(i);
      bufm[i] = 8'hA0 + 8'(i);
    end
    save_req = 1'b1; tick(); save_req = 1'b0; tick();
    chk("t3_save_busy", 32'(busy), 1);
    wait_idle("t3_idle_timeout");
    chk("t3_pause", 32'(pause_cpu), 0);
    upload_check();

    // Save requested mid-restore runs right after the restore
    do_reset();
    ram[CHKA] = CV;
    download(1'b1);
    vbl(36); vbl(36);
    chk("t4_in_restore", 32'(pause_cpu), 1);
    save_req = 1'b1; tick(); save_req = 1'b0;
    wait_restored("t4_restored_timeout");
    tick();
    chk("t4_save_follows", 32'(busy), 1);
    wait_idle("t4_idle_timeout");
    chk("t4_writes_left", 32'(exp_q.size()), 0);
    upload_check();

    // Reset in the middle of a save
    save_req = 1'b1; tick(); save_req = 1'b0;
    n = 0; found = 0;
    while (!found && n < 500) begin
      found = hs_access_read && hs_address == BASE + 12'd5;
      if (!found) begin tick(); n++; end
    end
    chk("t6_save_reached", 32'(found), 1);
    reset = 1'b1; tick();
    check_quiet("t6_reset", 0);
    reset = 1'b0;
    act = 0;
    repeat (200) begin
      tick();
      if (hs_access_read || hs_access_write || hs_write_enable || pause_cpu) act++;
    end
    chk("t6_no_activity", 32'(act), 0);

    // Download asserted while restore is on byte 10 aborts next clock
    ram[CHKA] = CV;
    download(1'b1);
    vbl(36); vbl(1);
    n = 0; found = 0;
    while (!found && n < 500) begin
      found = hs_access_write && !hs_write_enable && hs_address == BASE + 12'd10;
      if (!found) begin tick(); n++; end
    end
    chk("t5_byte10_reached", 32'(found), 1);
    ioctl_download = 1'b1; tick();
    check_quiet("t5_abort", 0);
    chk("t5_writes_done", 32'(exp_q.size()), LEN - 10);
    exp_q.delete();
    ioctl_download = 1'b0; repeat (3) tick();
    vbl(36); vbl(36); vbl(36);
    chk("t5_unloaded_idle", 32'(busy), 0);
    chk("t5_not_restored", 32'(restored), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
